// File: rtl/time_counter_param.sv
// time_counter_param: modulo-MODULUS up/down counter with count enable,
// synchronous load (clamped to MODULUS-1), a clock-enable prescaler and
// a one-cycle terminal-count pulse plus a sticky wrapped flag.
//
// Ports:
//   clk          rising-edge clock
//   clrn         synchronous active-low reset
//   enable       count enable; low holds count and prescaler
//   up           direction, 1 = up, 0 = down (sampled at each step)
//   load         synchronous load strobe (beats enable)
//   load_value   value to load, clamped to MODULUS-1
//   clr_wrapped  clears the sticky wrapped flag (a same-edge set wins)
//   count        current count, 0..MODULUS-1 (registered)
//   tc           one-cycle terminal-count pulse (registered)
//   wrapped      sticky flag, set whenever tc fires (registered)
module time_counter_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_wrapped,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the clamp.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  // Reject illegal parameter sets at elaboration.
  if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH)) ||
      (PRESCALE < 1)) begin : g_param_err
    $fatal(1, "time_counter_param: illegal WIDTH/MODULUS/PRESCALE");
  end

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pre;
  logic             r_tc;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_count_nxt;
  logic [PW-1:0]    w_pre_nxt;
  logic             w_tc_nxt;
  logic             w_wrapped_nxt;
  logic [WIDTH-1:0] w_load_clamped;

  assign w_load_clamped = ({1'b0, load_value} >= MOD_EXT) ? CNT_MAX : load_value;

  // Next-state: load beats step; tc only on a wrapping step.
  always_comb begin
    w_count_nxt   = r_count;
    w_pre_nxt     = r_pre;
    w_tc_nxt      = 1'b0;
    w_wrapped_nxt = r_wrapped & ~clr_wrapped;

    if (load) begin
      w_count_nxt = w_load_clamped;
      w_pre_nxt   = '0;
    end else if (enable) begin
      if (r_pre == PRE_MAX) begin
        w_pre_nxt = '0;
        if (up) begin
          if (r_count == CNT_MAX) begin
            w_count_nxt = '0;
            w_tc_nxt    = 1'b1;
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end else begin
          if (r_count == '0) begin
            w_count_nxt = CNT_MAX;
            w_tc_nxt    = 1'b1;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
      end else begin
        w_pre_nxt = r_pre + PW'(1);
      end
    end

    // Set beats a simultaneous clear.
    if (w_tc_nxt) begin
      w_wrapped_nxt = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_count   <= '0;
      r_pre     <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_pre     <= w_pre_nxt;
      r_tc      <= w_tc_nxt;
      r_wrapped <= w_wrapped_nxt;
    end
  end

  assign count   = r_count;
  assign tc      = r_tc;
  assign wrapped = r_wrapped;

endmodule
